lfsr_gen: RTL and testbench

- Parametrised Fibonacci LFSR. It generalises the fixed 4-bit seed/run LFSR to any width and tap polynomial.
- Adds an integrated tick divider, a single-step mode, zero-seed lock-up protection, wrap detection and a measured period output.
- Sits behind the board switch/button inputs and drives LEDs or a pseudo-random source for downstream blocks.

---
 rtl/lfsr_gen_pkg.sv | 58 +++++
 rtl/lfsr_gen_if.sv | 24 ++
 rtl/lfsr_gen_tick_div.sv | 27 ++
 rtl/lfsr_gen.sv | 85 ++++++++
 tb/tb_lfsr_gen.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/lfsr_gen_pkg.sv
// Shared definitions for the LFSR generator: input encodings and
// maximal-length feedback masks (bit i set = state[i] feeds the XOR).
package lfsr_gen_pkg;

  typedef enum logic {
    SEL_LOAD = 1'b0,
    SEL_RUN  = 1'b1
  } sel_e;

  typedef enum logic {
    MODE_FREE = 1'b0,
    MODE_STEP = 1'b1
  } mode_e;

  localparam int W_MIN = 3;
  localparam int W_MAX = 32;

  localparam logic [3:0] TAPS_4 = 4'b1100;
  localparam logic [7:0] TAPS_8 = 8'b10111000;

  // Maximal-length tap masks for a left-shifting Fibonacci register.
  function automatic logic [31:0] default_taps(input int w);
    case (w)
      3:       return 32'h0000_0006;
      4:       return 32'h0000_000C;
      5:       return 32'h0000_0014;
      6:       return 32'h0000_0030;
      7:       return 32'h0000_0060;
      8:       return 32'h0000_00B8;
      9:       return 32'h0000_0110;
      10:      return 32'h0000_0240;
      11:      return 32'h0000_0500;
      12:      return 32'h0000_0829;
      13:      return 32'h0000_100D;
      14:      return 32'h0000_2015;
      15:      return 32'h0000_6000;
      16:      return 32'h0000_D008;
      17:      return 32'h0001_2000;
      18:      return 32'h0002_0400;
      19:      return 32'h0004_0023;
      20:      return 32'h0009_0000;
      21:      return 32'h0014_0000;
      22:      return 32'h0030_0000;
      23:      return 32'h0042_0000;
      24:      return 32'h00E1_0000;
      25:      return 32'h0120_0000;
      26:      return 32'h0200_0023;
      27:      return 32'h0400_0013;
      28:      return 32'h0900_0000;
      29:      return 32'h1400_0000;
      30:      return 32'h2000_0029;
      31:      return 32'h4800_0000;
      32:      return 32'h8020_0003;
      default: return 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/lfsr_gen_if.sv
// Control and observation bundle between board inputs and the LFSR generator.
interface lfsr_gen_if #(
  parameter int W = 4
);
  logic [W-1:0] seed;
  logic         sel;
  logic         mode;
  logic         step;
  logic [W-1:0] state;
  logic         tick;
  logic         wrap;
  logic         lockup;
  logic [W-1:0] period;

  modport master (
    output seed, sel, mode, step,
    input  state, tick, wrap, lockup, period
  );

  modport slave (
    input  seed, sel, mode, step,
    output state, tick, wrap, lockup, period
  );
endinterface

// File: rtl/lfsr_gen_tick_div.sv
// Run-mode step divider: pulses tick combinationally on the last of every DIV
// enabled cycles; disabling it returns the count to zero.
module tick_div #(
  parameter int DIV = 50000000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);
  localparam int            DW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(DIV - 1);

  logic [DW-1:0] cnt_q;

  assign tick = en && (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (!en || (cnt_q == LAST)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
endmodule

// File: rtl/lfsr_gen.sv
// Fibonacci LFSR with seed load, free-run/single-step advance, zero-seed
// lock-up protection, wrap detection and measured period.
module lfsr_gen
  import lfsr_gen_pkg::*;
#(
  parameter int           W        = 4,
  parameter logic [W-1:0] TAPS     = W'(default_taps(W)),
  parameter int           DIV      = 50000000,
  parameter logic [W-1:0] SEED_RST = '1
) (
  input  logic       clk,
  input  logic       rst,
  lfsr_gen_if.slave  bus
);
  if (W < W_MIN || W > W_MAX) begin : g_bad_width
    $error("lfsr_gen: W must be in 3..32");
  end
  if (TAPS[W-1] != 1'b1) begin : g_bad_taps
    $error("lfsr_gen: TAPS[W-1] must be set");
  end
  if (SEED_RST == '0) begin : g_bad_seed
    $error("lfsr_gen: SEED_RST must be nonzero");
  end
  if (DIV < 1) begin : g_bad_div
    $error("lfsr_gen: DIV must be at least 1");
  end

  logic [W-1:0] state_q, cap_q, count_q, period_q;
  logic         tick_q, wrap_q, lock_q;
  logic         run, div_en, div_tick, adv, fb, seed_zero;
  logic [W-1:0] nxt, load_val;

  assign run       = (sel_e'(bus.sel) == SEL_RUN);
  assign div_en    = run && (mode_e'(bus.mode) == MODE_FREE);
  assign adv       = run && ((mode_e'(bus.mode) == MODE_STEP) ? bus.step : div_tick);
  assign fb        = ^(state_q & TAPS);
  assign nxt       = {state_q[W-2:0], fb};
  assign seed_zero = (bus.seed == '0);
  // A zero seed would freeze the register, so it is replaced by 0..01.
  assign load_val  = seed_zero ? W'(1) : bus.seed;

  tick_div #(.DIV(DIV)) u_div (
    .clk  (clk),
    .rst  (rst),
    .en   (div_en),
    .tick (div_tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= SEED_RST;
      cap_q    <= SEED_RST;
      count_q  <= '0;
      period_q <= '0;
      tick_q   <= 1'b0;
      wrap_q   <= 1'b0;
      lock_q   <= 1'b0;
    end else if (!run) begin
      state_q <= load_val;
      cap_q   <= load_val;
      lock_q  <= seed_zero;
      count_q <= '0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      tick_q <= adv;
      wrap_q <= adv && (nxt == cap_q);
      if (adv) begin
        state_q <= nxt;
        if (nxt == cap_q) begin
          period_q <= count_q + 1'b1;
          count_q  <= '0;
        end else begin
          count_q  <= count_q + 1'b1;
        end
      end
    end
  end

  assign bus.state  = state_q;
  assign bus.tick   = tick_q;
  assign bus.wrap   = wrap_q;
  assign bus.lockup = lock_q;
  assign bus.period = period_q;
endmodule

// File: tb/tb_lfsr_gen.sv
// Bench for lfsr_gen: a 4-bit/DIV=2 instance and an 8-bit/DIV=1 instance,
// both tracked every cycle by a cycle-level behavioural model.
module tb_lfsr_gen;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lfsr_gen_if #(.W(4)) if0 ();
  lfsr_gen_if #(.W(8)) if1 ();

  lfsr_gen #(.W(4), .DIV(2)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  lfsr_gen #(.W(8), .TAPS(8'b10111000), .DIV(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: per-instance parameters and spec-level state.
  localparam int          MW[2]   = '{4, 8};
  localparam int          MDIV[2] = '{2, 1};
  localparam logic [31:0] MTAP[2] = '{32'hC, 32'hB8};
  localparam logic [31:0] MRST[2] = '{32'hF, 32'hFF};

  logic [31:0] m_st[2], m_cap[2], m_per[2];
  int          m_runc[2], m_steps[2];
  bit          m_tick[2], m_wrap[2], m_lock[2];

  task automatic model_reset(input int k);
    m_st[k] = MRST[k]; m_cap[k] = MRST[k]; m_per[k] = 0;
    m_runc[k] = 0; m_steps[k] = 0;
    m_tick[k] = 0; m_wrap[k] = 0; m_lock[k] = 0;
  endtask

  task automatic model_edge(input int k, input logic [31:0] seed, input logic sel,
                            input logic mode, input logic step);
    logic [31:0] msk;
    bit adv;
    msk = (32'h1 << MW[k]) - 1;
    if (!sel) begin
      if ((seed & msk) == 0) begin
        m_st[k] = 1; m_cap[k] = 1; m_lock[k] = 1;
      end else begin
        m_st[k] = seed & msk; m_cap[k] = seed & msk; m_lock[k] = 0;
      end
      m_runc[k] = 0; m_steps[k] = 0; m_tick[k] = 0; m_wrap[k] = 0;
    end else begin
      adv = 0;
      if (!mode) begin
        m_runc[k]++;
        adv = (m_runc[k] % MDIV[k] == 0);
      end else begin
        m_runc[k] = 0;
        adv = step;
      end
      m_tick[k] = adv;
      m_wrap[k] = 0;
      if (adv) begin
        m_st[k] = ((m_st[k] << 1) | 32'($countones(m_st[k] & MTAP[k]) % 2)) & msk;
        m_steps[k]++;
        if (m_st[k] == m_cap[k]) begin
          m_wrap[k] = 1;
          m_per[k] = m_steps[k];
          m_steps[k] = 0;
        end
      end
    end
  endtask

  always @(posedge clk or negedge rst)
    if (!rst) model_reset(0);
    else model_edge(0, 32'(if0.seed), if0.sel, if0.mode, if0.step);

  always @(posedge clk or negedge rst)
    if (!rst) model_reset(1);
    else model_edge(1, 32'(if1.seed), if1.sel, if1.mode, if1.step);

  always @(negedge clk) begin
    check("m0_state",  32'(if0.state),  m_st[0]);
    check("m0_tick",   32'(if0.tick),   32'(m_tick[0]));
    check("m0_wrap",   32'(if0.wrap),   32'(m_wrap[0]));
    check("m0_lockup", 32'(if0.lockup), 32'(m_lock[0]));
    check("m0_period", 32'(if0.period), m_per[0]);
    check("m1_state",  32'(if1.state),  m_st[1]);
    check("m1_tick",   32'(if1.tick),   32'(m_tick[1]));
    check("m1_wrap",   32'(if1.wrap),   32'(m_wrap[1]));
    check("m1_lockup", 32'(if1.lockup), 32'(m_lock[1]));
    check("m1_period", 32'(if1.period), m_per[1]);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  logic [3:0] run_seq[15]  = '{4'hE, 4'hC, 4'h8, 4'h1, 4'h2, 4'h4, 4'h9, 4'h3,
                               4'h6, 4'hD, 4'hA, 4'h5, 4'hB, 4'h7, 4'hF};
  logic [3:0] step_seq[4]  = '{4'h2, 4'h4, 4'h9, 4'h3};

  initial begin
    logic [3:0] prev;
    int n;
    rst = 1'b0;
    if0.seed = 4'hF;  if0.sel = 1'b0; if0.mode = 1'b0; if0.step = 1'b0;
    if1.seed = 8'h01; if1.sel = 1'b0; if1.mode = 1'b0; if1.step = 1'b0;

    // reset state, held for three cycles
    repeat (3) @(negedge clk);
    check("rst_state",  32'(if0.state),  32'hF);
    check("rst_lockup", 32'(if0.lockup), 32'h0);
    check("rst_period", 32'(if0.period), 32'h0);
    rst = 1'b1;
    @(negedge clk);
    check("load_state",  32'(if0.state),  32'hF);
    check("load_period", 32'(if0.period), 32'h0);

    // free run, DIV=2: one advance every two cycles
    if0.sel = 1'b1; if0.mode = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      check("run_gap_tick", 32'(if0.tick), 32'h0);
      @(negedge clk);
      check("run_state", 32'(if0.state), 32'(run_seq[i]));
      check("run_tick",  32'(if0.tick),  32'h1);
      check("run_wrap",  32'(if0.wrap),  32'(i == 14));
    end
    check("run_period", 32'(if0.period), 32'd15);

    // single-step from 0001
    if0.sel = 1'b0; if0.seed = 4'h1; if0.mode = 1'b1;
    @(negedge clk);
    check("step_load", 32'(if0.state), 32'h1);
    if0.sel = 1'b1;
    prev = 4'h1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("step_hold", 32'(if0.state), 32'(prev));
      check("step_idle_tick", 32'(if0.tick), 32'h0);
      if0.step = 1'b1;
      @(negedge clk);
      if0.step = 1'b0;
      check("step_state", 32'(if0.state), 32'(step_seq[i]));
      check("step_tick",  32'(if0.tick),  32'h1);
      prev = step_seq[i];
    end

    // zero seed lock-up, then recovery
    if0.sel = 1'b0; if0.seed = 4'h0;
    @(negedge clk);
    check("zero_state",  32'(if0.state),  32'h1);
    check("zero_lockup", 32'(if0.lockup), 32'h1);
    if0.seed = 4'h5;
    @(negedge clk);
    check("reload_lockup", 32'(if0.lockup), 32'h0);
    check("reload_state",  32'(if0.state),  32'h5);

    // load beats a simultaneous step and clears the step count
    if0.sel = 1'b1; if0.step = 1'b1;
    @(negedge clk);
    check("pre_load_step", 32'(if0.state), 32'hB);
    if0.sel = 1'b0; if0.seed = 4'h6;
    @(negedge clk);
    check("loadwin_state", 32'(if0.state), 32'h6);
    check("loadwin_tick",  32'(if0.tick),  32'h0);
    if0.sel = 1'b1;
    repeat (15) @(negedge clk);
    if0.step = 1'b0;
    check("held_step_state",  32'(if0.state),  32'h6);
    check("held_step_wrap",   32'(if0.wrap),   32'h1);
    check("held_step_period", 32'(if0.period), 32'd15);

    // 8-bit instance, DIV=1, from seed 01
    if1.sel = 1'b1;
    n = 0;
    while (n < 400) begin
      @(negedge clk);
      n++;
      if (if1.wrap) break;
    end
    check("w8_wrap_cycles", 32'(n), 32'd255);
    check("w8_period",      32'(if1.period), 32'd255);
    check("w8_state",       32'(if1.state),  32'h01);

    // asynchronous reset takes effect between clock edges
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_rst_w8", 32'(if1.state), 32'hFF);
    check("async_rst_w4", 32'(if0.state), 32'hF);
    check("async_rst_period", 32'(if1.period), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
